// File: rtl/logic_gate_bank_pipe_pkg.sv
// logic_bank_pkg: mode codes, counter constants and the gate function shared by the bank
package logic_bank_pkg;
  localparam logic [2:0] MODE_AND  = 3'd0;
  localparam logic [2:0] MODE_NAND = 3'd1;
  localparam logic [2:0] MODE_OR   = 3'd2;
  localparam logic [2:0] MODE_NOR  = 3'd3;
  localparam logic [2:0] MODE_XOR  = 3'd4;
  localparam logic [2:0] MODE_XNOR = 3'd5;
  localparam logic [2:0] MODE_PASS = 3'd6;
  localparam logic [2:0] MODE_NOTA = 3'd7;
  localparam int OPS_W = 16;
  localparam logic [OPS_W-1:0] OPS_SAT = '1;
  // Widest bank supported; callers truncate the result to their channel count.
  localparam int GATE_MAX_W = 32;
  function automatic logic [GATE_MAX_W-1:0] gate_fn(input logic [2:0] mode,
                                                     input logic [GATE_MAX_W-1:0] a,
                                                     input logic [GATE_MAX_W-1:0] b);
    case (mode)
      MODE_AND:  gate_fn = a & b;
      MODE_NAND: gate_fn = ~(a & b);
      MODE_OR:   gate_fn = a | b;
      MODE_NOR:  gate_fn = ~(a | b);
      MODE_XOR:  gate_fn = a ^ b;
      MODE_XNOR: gate_fn = ~(a ^ b);
      MODE_PASS: gate_fn = a;
      default:   gate_fn = ~a;
    endcase
  endfunction
endpackage

// File: rtl/logic_gate_bank_pipe_if.sv
// logic_gate_bank_pipe_if: input/output handshake bundle of the gate bank (parity signals under LOGIC_BANK_PARITY_EN)
interface logic_gate_bank_pipe_if #(parameter int WIDTH = 4);
  import logic_bank_pkg::*;
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       MODE;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] Y;
  logic             ZERO;
  logic [OPS_W-1:0] OPS_CNT;
`ifdef LOGIC_BANK_PARITY_EN
  logic             PAR;
  logic             PAR_INV;
  modport master (output IN_VALID, A, B, MODE, OUT_READY, PAR_INV,
                  input  IN_READY, OUT_VALID, Y, ZERO, OPS_CNT, PAR);
  modport slave  (input  IN_VALID, A, B, MODE, OUT_READY, PAR_INV,
                  output IN_READY, OUT_VALID, Y, ZERO, OPS_CNT, PAR);
`else
  modport master (output IN_VALID, A, B, MODE, OUT_READY,
                  input  IN_READY, OUT_VALID, Y, ZERO, OPS_CNT);
  modport slave  (input  IN_VALID, A, B, MODE, OUT_READY,
                  output IN_READY, OUT_VALID, Y, ZERO, OPS_CNT);
`endif
endinterface

// File: rtl/logic_gate_bank_pipe_stage.sv
// logic_bank_stage: one valid/ready register stage holding a W-bit payload
module logic_bank_stage #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         ready_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);
  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  // Advance when this stage may load; data only moves with a valid item so idle cycles do not toggle it.
  always_comb begin
    valid_d = ready_i ? valid_i : valid_q;
    data_d  = (ready_i && valid_i) ? data_i : data_q;
  end
  // Stage registers, cleared asynchronously so reset drops any in-flight item.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

// File: rtl/logic_gate_bank_pipe.sv
// logic_gate_bank_pipe: WIDTH-channel selectable gate bank behind STAGES valid/ready registers (option LOGIC_BANK_PARITY_EN adds PAR/PAR_INV)
module logic_gate_bank_pipe
  import logic_bank_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input logic                 CLK,
  input logic                 CLR_N,
  logic_gate_bank_pipe_if.slave bus
);
`ifdef LOGIC_BANK_PARITY_EN
  localparam int PW = WIDTH + 2;
`else
  localparam int PW = WIDTH + 1;
`endif
  logic [WIDTH-1:0] fn_y;
  logic [STAGES:0]  vld;
  logic [PW-1:0]    data [STAGES+1];
  logic [STAGES-1:0] rdy;
  logic [OPS_W-1:0] ops_cnt_q, ops_cnt_d;
  assign fn_y   = WIDTH'(gate_fn(bus.MODE, GATE_MAX_W'(bus.A), GATE_MAX_W'(bus.B)));
  assign vld[0] = bus.IN_VALID;
`ifdef LOGIC_BANK_PARITY_EN
  assign data[0] = {fn_y, ~|fn_y, ^fn_y ^ bus.PAR_INV};
  assign bus.PAR = data[STAGES][0];
`else
  assign data[0] = {fn_y, ~|fn_y};
`endif
  // Unrolled form of ready_k = !valid_k || ready_(k+1): stage k may load when
  // OUT_READY is high or any stage from k to the last is empty. This keeps the
  // ready chain free of combinational self-reference.
  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    assign rdy[g] = bus.OUT_READY || !(&vld[STAGES:g+1]);
    logic_bank_stage #(.W(PW)) u_stage (
      .clk_i   (CLK),
      .rst_ni  (CLR_N),
      .ready_i (rdy[g]),
      .valid_i (vld[g]),
      .data_i  (data[g]),
      .valid_o (vld[g+1]),
      .data_o  (data[g+1])
    );
  end
  assign bus.IN_READY  = rdy[0];
  assign bus.OUT_VALID = vld[STAGES];
  assign bus.Y         = data[STAGES][PW-1 -: WIDTH];
  assign bus.ZERO      = data[STAGES][PW-WIDTH-1];
  assign bus.OPS_CNT   = ops_cnt_q;
  // Count output handshakes, sticking at the saturation value.
  always_comb ops_cnt_d = (bus.OUT_VALID && bus.OUT_READY && ops_cnt_q != OPS_SAT) ? ops_cnt_q + 1'b1 : ops_cnt_q;
  // Handshake counter register.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) ops_cnt_q <= '0;
    else ops_cnt_q <= ops_cnt_d;
  end
endmodule

// File: tb/tb_logic_gate_bank_pipe.sv
// tb_logic_gate_bank_pipe: directed and random stimulus against a truth-table queue model
module tb_logic_gate_bank_pipe;
  localparam int W = 4;
  localparam int S = 2;
  // Truth tables per mode, 4 bits each indexed by {a,b}; mode 0 in the low nibble.
  localparam logic [31:0] TT = 32'h3C961E78;
  typedef struct {
    logic [W-1:0] y;
    logic         par;
    int           acc;
  } item_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic_gate_bank_pipe_if #(.WIDTH(W)) bus();
  logic_gate_bank_pipe #(.WIDTH(W), .STAGES(S)) dut (.CLK(clk), .CLR_N(rst_n), .bus(bus));
  item_t q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_out = -1;
  logic [15:0] cnt_m = '0;
  logic acc;
  int idx;
  logic [15:0] base;
  logic [W-1:0] ia [4];
  logic [W-1:0] ib [4];
  logic [2:0]   im [4];

  function automatic logic [W-1:0] model(input logic [2:0] m, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = TT[int'(m) * 4 + 2 * int'(a[i]) + int'(b[i])];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] m,
                      input logic inv, input logic ordy, output logic accepted);
    logic exp_rdy, exp_v;
    logic [W-1:0] y;
    int due;
    bus.IN_VALID = iv;
    bus.A = a;
    bus.B = b;
    bus.MODE = m;
    bus.OUT_READY = ordy;
`ifdef LOGIC_BANK_PARITY_EN
    bus.PAR_INV = inv;
`endif
    #1;
    exp_rdy = (q.size() < S) || ordy;
    exp_v = 1'b0;
    if (q.size() > 0) begin
      due = q[0].acc + S;
      if (last_out + 1 > due) due = last_out + 1;
      exp_v = cyc >= due;
    end
    chk("in_ready", 32'(bus.IN_READY), 32'(exp_rdy));
    chk("out_valid", 32'(bus.OUT_VALID), 32'(exp_v));
    chk("ops_cnt", 32'(bus.OPS_CNT), 32'(cnt_m));
    if (exp_v) begin
      chk("y", 32'(bus.Y), 32'(q[0].y));
      chk("zero", 32'(bus.ZERO), 32'(q[0].y == '0));
`ifdef LOGIC_BANK_PARITY_EN
      chk("par", 32'(bus.PAR), 32'(q[0].par));
`endif
      if (ordy) begin
        void'(q.pop_front());
        last_out = cyc;
        if (cnt_m != 16'hFFFF) cnt_m++;
      end
    end
    accepted = iv && exp_rdy;
    if (accepted) begin
      y = model(m, a, b);
      q.push_back('{y: y, par: (^y) ^ inv, acc: cyc});
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input int budget);
    logic a;
    for (int i = 0; i < budget && q.size() > 0; i++) step(1'b0, '0, '0, 3'd0, 1'b0, 1'b1, a);
    chk("drain_empty", 32'(q.size()), 32'd0);
    step(1'b0, '0, '0, 3'd0, 1'b0, 1'b1, a);
  endtask

  initial begin
    bus.IN_VALID = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.MODE = '0;
    bus.OUT_READY = 1'b1;
`ifdef LOGIC_BANK_PARITY_EN
    bus.PAR_INV = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(bus.OUT_VALID), 32'd0);
    chk("rst_y", 32'(bus.Y), 32'd0);
    chk("rst_zero", 32'(bus.ZERO), 32'd0);
    chk("rst_ops", 32'(bus.OPS_CNT), 32'd0);
    chk("rst_in_ready", 32'(bus.IN_READY), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    // Every mode on A=1100, B=1010 at full rate.
    for (int m = 0; m < 8; m++) step(1'b1, 4'b1100, 4'b1010, 3'(m), 1'b0, 1'b1, acc);
    drain(10);
    // ZERO flag both ways.
    step(1'b1, 4'b0000, 4'b1111, 3'd0, 1'b0, 1'b1, acc);
    step(1'b1, 4'b1111, 4'b1111, 3'd0, 1'b1, 1'b1, acc);
    drain(10);
    // Back-pressure: four items, output stalled for five cycles.
    for (int i = 0; i < 4; i++) begin
      ia[i] = 4'($urandom);
      ib[i] = 4'($urandom);
      im[i] = 3'($urandom);
    end
    base = cnt_m;
    idx = 0;
    for (int t = 0; t < 5; t++) begin
      step(idx < 4, ia[idx % 4], ib[idx % 4], im[idx % 4], 1'($urandom), 1'b0, acc);
      if (acc) idx++;
    end
    chk("bp_accepted", 32'(idx), 32'(S));
    for (int t = 0; t < 20 && (idx < 4 || q.size() > 0); t++) begin
      step(idx < 4, ia[idx % 4], ib[idx % 4], im[idx % 4], 1'($urandom), 1'b1, acc);
      if (acc) idx++;
    end
    drain(10);
    chk("bp_ops", 32'(bus.OPS_CNT), 32'(base + 16'd4));
    // Full-rate random stream.
    base = cnt_m;
    for (int i = 0; i < 100; i++) step(1'b1, 4'($urandom), 4'($urandom), 3'($urandom), 1'($urandom), 1'b1, acc);
    drain(10);
    chk("stream_ops", 32'(bus.OPS_CNT), 32'(base + 16'd100));
    // Random valid and ready.
    for (int i = 0; i < 300; i++)
      step(1'($urandom), 4'($urandom), 4'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), acc);
    drain(20);
    // Reset with two items in flight.
    step(1'b1, 4'b1111, 4'b0101, 3'd2, 1'b0, 1'b1, acc);
    step(1'b1, 4'b0011, 4'b0101, 3'd4, 1'b0, 1'b1, acc);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.OUT_VALID), 32'd0);
    chk("midrst_y", 32'(bus.Y), 32'd0);
    chk("midrst_ops", 32'(bus.OPS_CNT), 32'd0);
    q.delete();
    cnt_m = '0;
    last_out = -1;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_in_ready", 32'(bus.IN_READY), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 3'd0, 1'b0, 1'b1, acc);
    // Saturation: preload the counter near its ceiling.
    force dut.ops_cnt_q = 16'hFFFD;
    @(posedge clk);
    @(negedge clk);
    release dut.ops_cnt_q;
    cnt_m = 16'hFFFD;
    for (int i = 0; i < 6; i++) step(1'b1, 4'($urandom), 4'($urandom), 3'($urandom), 1'b0, 1'b1, acc);
    drain(10);
    chk("sat_ops", 32'(bus.OPS_CNT), 32'hFFFF);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
